// File: rtl/sig_gen_pkt.sv
// Avalon-ST test-pattern source with fixed-length packets and an Avalon-MM CSR slave.
// Optional error injection on CTRL[4] is built when SIG_GEN_ERR_INJECT_EN is defined.
module sig_gen_pkt #(
  parameter int DATA_W      = 32,
  parameter int ERR_W       = 8,
  parameter int LEN_W       = 16,
  parameter int DEF_PKT_LEN = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              aso_valid,
  output logic [DATA_W-1:0] aso_data,
  output logic              aso_startofpacket,
  output logic              aso_endofpacket,
  output logic [ERR_W-1:0]  aso_error,
  input  logic              aso_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [LEN_W-1:0]  ONE_LEN  = LEN_W'(1);
  localparam logic [DATA_W-1:0] ONE_DATA = DATA_W'(1);

  logic [0:0]        state_reg;
  logic              enable_reg;
  logic [1:0]        mode_reg;
  logic [DATA_W-1:0] seed_reg;
  logic [DATA_W-1:0] step_reg;
  logic [LEN_W-1:0]  pkt_len_reg;
  logic [31:0]       beats_reg;
  logic [31:0]       pkts_reg;
  logic [DATA_W-1:0] cur_reg;
  logic [LEN_W-1:0]  beat_idx_reg;
  logic [LEN_W-1:0]  len_reg;
  logic              reload_pend_reg;
  logic              err_rd;

  logic              wr_ctrl;
  logic              idle;
  logic              starting;
  logic              load;
  logic              accept;
  logic              apply_reload;
  logic              last;
  logic [DATA_W-1:0] cur_eff;
  logic [DATA_W-1:0] cur_adv;
  logic [LEN_W-1:0]  idx_eff;
  logic [LEN_W-1:0]  len_eff;
  logic [63:0]       seed_ext;
  logic [63:0]       step_ext;
  logic [63:0]       len_ext;
  logic [31:0]       rd_mux;

  always_comb begin
    wr_ctrl      = avs_write && (avs_address == 3'd0);
    idle         = (state_reg == ST_IDLE);
    starting     = idle && enable_reg;
    load         = ((state_reg == ST_RUN) || starting) && (!aso_valid || aso_ready);
    accept       = aso_valid && aso_ready;
    // A pending reload only lands between packets so a packet never mixes seeds.
    apply_reload = reload_pend_reg && idle;
    cur_eff      = apply_reload ? seed_reg : cur_reg;
    idx_eff      = apply_reload ? '0 : beat_idx_reg;
    len_eff      = idle ? ((pkt_len_reg == '0) ? ONE_LEN : pkt_len_reg) : len_reg;
    last         = (idx_eff == (len_eff - ONE_LEN));
    case (mode_reg)
      2'd0:    cur_adv = cur_eff + step_reg;
      2'd1:    cur_adv = cur_eff - step_reg;
      2'd2:    cur_adv = seed_reg;
      default: cur_adv = (cur_eff == '0) ? ONE_DATA : {cur_eff[DATA_W-2:0], cur_eff[DATA_W-1]};
    endcase
  end

  always_comb begin
    seed_ext = 64'(seed_reg);
    step_ext = 64'(step_reg);
    len_ext  = 64'(pkt_len_reg);
    case (avs_address)
      3'd0:    rd_mux = {27'd0, err_rd, 1'b0, mode_reg, enable_reg};
      3'd1:    rd_mux = seed_ext[31:0];
      3'd2:    rd_mux = step_ext[31:0];
      3'd3:    rd_mux = len_ext[31:0];
      3'd4:    rd_mux = beats_reg;
      3'd5:    rd_mux = pkts_reg;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata    <= '0;
      enable_reg      <= 1'b0;
      mode_reg        <= '0;
      seed_reg        <= '0;
      step_reg        <= ONE_DATA;
      pkt_len_reg     <= LEN_W'(DEF_PKT_LEN);
      beats_reg       <= '0;
      pkts_reg        <= '0;
      reload_pend_reg <= 1'b0;
    end else begin
      avs_readdata <= avs_read ? rd_mux : '0;
      if (avs_write) begin
        case (avs_address)
          3'd0: begin
            enable_reg <= avs_writedata[0];
            mode_reg   <= avs_writedata[2:1];
          end
          3'd1:    seed_reg    <= DATA_W'(avs_writedata);
          3'd2:    step_reg    <= DATA_W'(avs_writedata);
          3'd3:    pkt_len_reg <= LEN_W'(avs_writedata);
          default: ;
        endcase
      end
      if (wr_ctrl && avs_writedata[3])
        reload_pend_reg <= 1'b1;
      else if (apply_reload)
        reload_pend_reg <= 1'b0;
      if (avs_write && (avs_address == 3'd4))
        beats_reg <= '0;
      else if (accept)
        beats_reg <= beats_reg + 32'd1;
      if (avs_write && (avs_address == 3'd5))
        pkts_reg <= '0;
      else if (accept && aso_endofpacket)
        pkts_reg <= pkts_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      cur_reg           <= '0;
      beat_idx_reg      <= '0;
      len_reg           <= '0;
      aso_valid         <= 1'b0;
      aso_data          <= '0;
      aso_startofpacket <= 1'b0;
      aso_endofpacket   <= 1'b0;
    end else begin
      if (starting)
        len_reg <= len_eff;
      if (load) begin
        aso_valid         <= 1'b1;
        aso_data          <= cur_eff;
        aso_startofpacket <= (idx_eff == '0);
        aso_endofpacket   <= last;
        cur_reg           <= cur_adv;
        beat_idx_reg      <= last ? '0 : idx_eff + ONE_LEN;
        state_reg         <= last ? ST_IDLE : ST_RUN;
      end else begin
        if (accept)
          aso_valid <= 1'b0;
        if (apply_reload) begin
          cur_reg      <= seed_reg;
          beat_idx_reg <= '0;
        end
        if (starting)
          state_reg <= ST_RUN;
      end
    end
  end

`ifdef SIG_GEN_ERR_INJECT_EN
  logic err_pend_reg;

  assign err_rd = err_pend_reg;

  // A new request wins over a load in the same cycle, so it is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pend_reg <= 1'b0;
      aso_error    <= '0;
    end else begin
      if (wr_ctrl && avs_writedata[4])
        err_pend_reg <= 1'b1;
      else if (load)
        err_pend_reg <= 1'b0;
      if (load)
        aso_error <= err_pend_reg ? ERR_W'(1) : '0;
    end
  end
`else
  assign err_rd    = 1'b0;
  assign aso_error = '0;
`endif

endmodule

// File: tb/tb_sig_gen_pkt.sv
// Directed bench for sig_gen_pkt (DATA_W=8): scoreboard of expected beats, CSR checks.
module tb_sig_gen_pkt;

  logic        clk;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        aso_valid;
  logic [7:0]  aso_data;
  logic        aso_startofpacket;
  logic        aso_endofpacket;
  logic [7:0]  aso_error;
  logic        aso_ready;

`ifdef SIG_GEN_ERR_INJECT_EN
  localparam logic [7:0] INJ_ERR = 8'h01;
`else
  localparam logic [7:0] INJ_ERR = 8'h00;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [7:0] err;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_beat;
  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic found;
  int unsigned rst_vals[6] = '{0, 0, 1, 16, 0, 0};

  sig_gen_pkt #(.DATA_W(8), .ERR_W(8), .LEN_W(16), .DEF_PKT_LEN(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avs_address(avs_address),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_read(avs_read),
    .avs_readdata(avs_readdata),
    .aso_valid(aso_valid),
    .aso_data(aso_data),
    .aso_startofpacket(aso_startofpacket),
    .aso_endofpacket(aso_endofpacket),
    .aso_error(aso_error),
    .aso_ready(aso_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic s, input logic e, input logic [7:0] er);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.err = er;
    exp_q.push_back(b);
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle_valid"}, 64'(aso_valid), 64'd0);
  endtask

  // Scoreboard: every accepted beat is compared against the head of the queue.
  always @(negedge clk) begin
    if (reset_n && aso_valid && aso_ready) begin
      $display("beat data=%02h sop=%0b eop=%0b err=%02h", aso_data, aso_startofpacket,
               aso_endofpacket, aso_error);
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_beat = exp_q.pop_front();
        check("beat_data", 64'(aso_data), 64'(mon_beat.data));
        check("beat_sop", 64'(aso_startofpacket), 64'(mon_beat.sop));
        check("beat_eop", 64'(aso_endofpacket), 64'(mon_beat.eop));
        check("beat_err", 64'(aso_error), 64'(mon_beat.err));
      end
    end
  end

  initial begin
    reset_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
    avs_read = 1'b0; aso_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_aso_in_reset", {aso_valid, aso_startofpacket, aso_endofpacket, aso_data, aso_error}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 6; a++) begin
      csr_read(3'(a), rd);
      check($sformatf("rst_csr%0d", a), 64'(rd), 64'(rst_vals[a]));
    end
    check("rst_aso", {aso_valid, aso_startofpacket, aso_endofpacket, aso_data, aso_error}, 64'd0);

    // Two back-to-back 4-beat packets, step 2, mode 0.
    csr_write(3'd3, 32'd4);
    csr_write(3'd2, 32'd2);
    for (int i = 0; i < 8; i++) push(8'(2 * i), (i % 4) == 0, (i % 4) == 3, 8'h00);
    aso_ready = 1'b1;
    csr_write(3'd0, 32'h1);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_valid", 64'(aso_valid), 64'd1);
      if (i == 3) begin avs_address = 3'd0; avs_writedata = 32'h0; avs_write = 1'b1; end
      if (i == 4) avs_write = 1'b0;
    end
    @(negedge clk);
    check("b2b_end_valid", 64'(aso_valid), 64'd0);
    csr_read(3'd4, rd); check("b2b_beats", 64'(rd), 64'd8);
    csr_read(3'd5, rd); check("b2b_pkts", 64'(rd), 64'd2);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Stall three cycles on beat 2.
    csr_write(3'd4, 32'd0);
    csr_write(3'd5, 32'd0);
    for (int i = 0; i < 4; i++) push(8'(16 + 2 * i), i == 0, i == 3, 8'h00);
    csr_write(3'd0, 32'h1);
    csr_write(3'd0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (aso_valid && aso_data == 8'd20) found = 1'b1;
    end
    check("stall_found_beat2", 64'(found), 64'd1);
    aso_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", {aso_valid, aso_startofpacket, aso_endofpacket, aso_data}, {1'b1, 1'b0, 1'b0, 8'd20});
      @(posedge clk);
    end
    #1;
    aso_ready = 1'b1;
    wait_drain("stall");
    csr_read(3'd4, rd); check("stall_beats", 64'(rd), 64'd4);
    csr_read(3'd5, rd); check("stall_pkts", 64'(rd), 64'd1);

    // 8-bit wrap and the other modes, each a 3-beat packet after reload.
    csr_write(3'd1, 32'hFE);
    csr_write(3'd2, 32'd1);
    csr_write(3'd3, 32'd3);
    push(8'hFE, 1'b1, 1'b0, 8'h00); push(8'hFF, 1'b0, 1'b0, 8'h00); push(8'h00, 1'b0, 1'b1, 8'h00);
    csr_write(3'd0, 32'h9);
    csr_write(3'd0, 32'h0);
    wait_drain("wrap");
    csr_write(3'd1, 32'h80);
    push(8'h80, 1'b1, 1'b0, 8'h00); push(8'h01, 1'b0, 1'b0, 8'h00); push(8'h02, 1'b0, 1'b1, 8'h00);
    csr_write(3'd0, 32'hF);
    csr_write(3'd0, 32'h6);
    wait_drain("rotate");
    csr_write(3'd1, 32'h01);
    csr_write(3'd2, 32'd3);
    push(8'h01, 1'b1, 1'b0, 8'h00); push(8'hFE, 1'b0, 1'b0, 8'h00); push(8'hFB, 1'b0, 1'b1, 8'h00);
    csr_write(3'd0, 32'hB);
    csr_write(3'd0, 32'h2);
    wait_drain("decrement");
    csr_write(3'd1, 32'h55);
    push(8'h55, 1'b1, 1'b0, 8'h00); push(8'h55, 1'b0, 1'b0, 8'h00); push(8'h55, 1'b0, 1'b1, 8'h00);
    csr_write(3'd0, 32'hD);
    csr_write(3'd0, 32'h4);
    wait_drain("constant");

    // Disable during beat 1 of a 4-beat packet.
    csr_write(3'd5, 32'd0);
    csr_write(3'd1, 32'h10);
    csr_write(3'd2, 32'd1);
    csr_write(3'd3, 32'd4);
    for (int i = 0; i < 4; i++) push(8'(16 + i), i == 0, i == 3, 8'h00);
    csr_write(3'd0, 32'h9);
    @(posedge clk); #1;
    csr_write(3'd0, 32'h0);
    wait_drain("disable");
    csr_read(3'd5, rd); check("disable_pkts", 64'(rd), 64'd1);

    // Error inject requested while the first beat is stalled.
    aso_ready = 1'b0;
    csr_write(3'd1, 32'h20);
    csr_write(3'd3, 32'd3);
    push(8'h20, 1'b1, 1'b0, 8'h00); push(8'h21, 1'b0, 1'b0, INJ_ERR); push(8'h22, 1'b0, 1'b1, 8'h00);
    csr_write(3'd0, 32'h9);
    csr_write(3'd0, 32'h10);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("inj_hold", {aso_valid, aso_data, aso_error}, {1'b1, 8'h20, 8'h00});
    end
    @(posedge clk); #1;
    aso_ready = 1'b1;
    wait_drain("inject");

    // Reset while a packet is in flight.
    aso_ready = 1'b0;
    csr_write(3'd0, 32'h1);
    @(posedge clk); #1;
    check("midrst_valid_before", 64'(aso_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_aso", {aso_valid, aso_startofpacket, aso_endofpacket, aso_data}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    csr_read(3'd3, rd); check("midrst_pkt_len", 64'(rd), 64'd16);
    csr_read(3'd0, rd); check("midrst_ctrl", 64'(rd), 64'd0);
    check("midrst_valid_after", 64'(aso_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
